// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between two requesters with round-robin arbitration.
// Operands are registered onto the ALU, y is captured after EXEC_CYCLES and held until rsp_ready.
module alu_share_ctrl #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic [2:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  input  logic [2:0]       req1_sel,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [2:0]       alu_sel,
  input  logic [16:0]      alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [16:0]      rsp_data,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count0,
  output logic [CNT_W-1:0] op_count1
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  state_t           state_q;
  logic             last_q;
  logic             gnt_id_q;
  logic [3:0]       exec_cnt_q;
  logic [15:0]      alu_a_q;
  logic [15:0]      alu_b_q;
  logic [2:0]       alu_sel_q;
  logic             rsp_valid_q;
  logic [16:0]      rsp_data_q;
  logic             rsp_id_q;
  logic [CNT_W-1:0] op_count0_q, op_count0_d;
  logic [CNT_W-1:0] op_count1_q, op_count1_d;

  logic grant0, grant1, hs0, hs1, rsp_hs;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_q);
    grant1 = req1_valid && (!req0_valid || !last_q);
  end

  assign req0_ready = (state_q == IDLE) && !rst && grant0;
  assign req1_ready = (state_q == IDLE) && !rst && grant1;
  assign hs0        = req0_valid && req0_ready;
  assign hs1        = req1_valid && req1_ready;
  assign rsp_hs     = (state_q == RESP) && rsp_valid_q && rsp_ready;

  always_comb begin
    op_count0_d = op_count0_q;
    op_count1_d = op_count1_q;
    if (rsp_hs) begin
      if (!rsp_id_q && (op_count0_q != '1)) op_count0_d = op_count0_q + CNT_W'(1);
      if (rsp_id_q && (op_count1_q != '1))  op_count1_d = op_count1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      gnt_id_q    <= 1'b0;
      exec_cnt_q  <= 4'd0;
      alu_a_q     <= 16'd0;
      alu_b_q     <= 16'd0;
      alu_sel_q   <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 17'd0;
      rsp_id_q    <= 1'b0;
      op_count0_q <= '0;
      op_count1_q <= '0;
    end else begin
      op_count0_q <= op_count0_d;
      op_count1_q <= op_count1_d;
      case (state_q)
        IDLE: begin
          if (hs0 || hs1) begin
            alu_a_q    <= hs1 ? req1_a : req0_a;
            alu_b_q    <= hs1 ? req1_b : req0_b;
            alu_sel_q  <= hs1 ? req1_sel : req0_sel;
            gnt_id_q   <= hs1;
            last_q     <= hs1;
            exec_cnt_q <= EXEC_LOAD;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          if (exec_cnt_q == 4'd0) begin
            rsp_data_q  <= alu_y;
            rsp_id_q    <= gnt_id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            exec_cnt_q <= exec_cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);
  assign op_count0 = op_count0_q;
  assign op_count1 = op_count1_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a stand-in ALU drives alu_y, a scoreboard checks responses in order.
module tb_alu_share_ctrl;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [2:0] req0_sel, req1_sel, alu_sel;
  logic [16:0] alu_y, rsp_data;
  logic rsp_valid, rsp_ready, rsp_id, busy;
  logic [CW-1:0] op_count0, op_count1;

  logic x_req0_valid, x_req0_ready, x_req1_ready, x_rsp_valid, x_rsp_ready, x_rsp_id, x_busy;
  logic [15:0] x_req0_a, x_req0_b, x_alu_a, x_alu_b;
  logic [2:0] x_req0_sel, x_alu_sel;
  logic [16:0] x_alu_y, x_rsp_data;
  logic [CW-1:0] x_op_count0, x_op_count1;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  function automatic logic [16:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
    case (s)
      3'b000: alu_f = {1'b0, a} + {1'b0, b};
      3'b001: alu_f = {1'b0, a - b};
      3'b010: alu_f = {1'b0, a & b};
      3'b011: alu_f = {1'b0, a | b};
      3'b100: alu_f = {1'b0, a ^ b};
      3'b101: alu_f = {1'b0, ~a};
      3'b110: alu_f = {1'b0, a << b[3:0]};
      default: alu_f = {1'b0, a >> b[3:0]};
    endcase
  endfunction

  assign alu_y   = alu_f(alu_a, alu_b, alu_sel);
  assign x_alu_y = alu_f(x_alu_a, x_alu_b, x_alu_sel);

  alu_share_ctrl #(.EXEC_CYCLES(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .op_count0(op_count0), .op_count1(op_count1)
  );

  alu_share_ctrl #(.EXEC_CYCLES(4), .CNT_W(CW)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(x_req0_valid), .req0_ready(x_req0_ready), .req0_a(x_req0_a), .req0_b(x_req0_b), .req0_sel(x_req0_sel),
    .req1_valid(1'b0), .req1_ready(x_req1_ready), .req1_a(16'd0), .req1_b(16'd0), .req1_sel(3'd0),
    .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_sel(x_alu_sel), .alu_y(x_alu_y),
    .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_data(x_rsp_data), .rsp_id(x_rsp_id),
    .busy(x_busy), .op_count0(x_op_count0), .op_count1(x_op_count1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {logic id; logic [16:0] y;} exp_t;
  exp_t sb[$];
  exp_t rsp_log[$];
  int m_cnt0 = 0;
  int m_cnt1 = 0;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("op_count0", 32'(op_count0), 32'(m_cnt0));
      chk("op_count1", 32'(op_count1), 32'(m_cnt1));
      if (rst) begin
        sb.delete();
        m_cnt0 = 0;
        m_cnt1 = 0;
      end else begin
        if (req0_valid && req0_ready) sb.push_back('{1'b0, alu_f(req0_a, req0_b, req0_sel)});
        if (req1_valid && req1_ready) sb.push_back('{1'b1, alu_f(req1_a, req1_b, req1_sel)});
        if (rsp_valid && rsp_ready) begin
          rsp_log.push_back('{rsp_id, rsp_data});
          if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("sb_data", 32'(rsp_data), 32'(e.y));
            chk("sb_id", 32'(rsp_id), 32'(e.id));
            if (e.id) begin
              if (m_cnt1 < SAT) m_cnt1++;
            end else begin
              if (m_cnt0 < SAT) m_cnt0++;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  // Issues n grants; both requesters alternate when both are active.
  task automatic run_ops(input int n, input bit use0, input bit use1, input bit first_id);
    int grants = 0;
    int cyc = 0;
    bit exp_id = first_id;
    bit g0, g1;
    req0_valid = use0;
    req1_valid = use1;
    while (grants < n && cyc < 40 * n) begin
      @(negedge clk);
      g0 = req0_ready;
      g1 = req1_ready;
      if (g0 || g1) begin
        chk("grant_id", 32'(g1), 32'(exp_id));
        chk("grant_onehot", 32'(g0 & g1), 32'd0);
        grants++;
        if (use0 && use1) exp_id = ~exp_id;
      end
      step();
      cyc++;
      if (g0) begin
        req0_a = 16'($urandom); req0_b = 16'($urandom); req0_sel = 3'($urandom_range(0, 7));
      end
      if (g1) begin
        req1_a = 16'($urandom); req1_b = 16'($urandom); req1_sel = 3'($urandom_range(0, 7));
      end
      if (grants >= n) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    if (grants < n) chk("grant_timeout", 32'(grants), 32'(n));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    rsp_ready = 0;
    x_req0_valid = 0; x_req0_a = 0; x_req0_b = 0; x_req0_sel = 0; x_rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    @(negedge clk);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);

    // Single operation, EXEC_CYCLES=1
    step();
    req0_valid = 1; req0_a = 16'hF0F0; req0_b = 16'h0FF0; req0_sel = 3'b010; rsp_ready = 1;
    @(negedge clk);
    chk("single_ready0", 32'(req0_ready), 32'd1);
    chk("single_ready1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 0;
    @(negedge clk);
    chk("single_alu_a", 32'(alu_a), 32'hF0F0);
    chk("single_alu_b", 32'(alu_b), 32'h0FF0);
    chk("single_alu_sel", 32'(alu_sel), 32'd2);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_early_rsp", 32'(rsp_valid), 32'd0);
    step();
    @(negedge clk);
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_data", 32'(rsp_data), 32'h000F0);
    chk("single_rsp_id", 32'(rsp_id), 32'd0);
    step();
    @(negedge clk);
    chk("single_count0", 32'(op_count0), 32'd1);
    chk("single_idle", 32'(busy), 32'd0);

    // Ties after reset alternate, starting with requester 0
    do_reset();
    rsp_log.delete();
    req0_a = 16'h00FF; req0_b = 16'hFF00; req0_sel = 3'b011;
    req1_a = 16'h0001; req1_b = 16'h0004; req1_sel = 3'b110;
    run_ops(6, 1'b1, 1'b1, 1'b0);
    if (rsp_log.size() >= 2) begin
      chk("tie_first", 32'(rsp_log[0]), 32'({1'b0, 17'h0FFFF}));
      chk("tie_second", 32'(rsp_log[1]), 32'({1'b1, 17'h00010}));
    end else begin
      chk("tie_rsp_count", 32'(rsp_log.size()), 32'd6);
    end

    // Backpressure in RESP
    step();
    rsp_ready = 0;
    req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h00FF; req0_sel = 3'b100;
    @(negedge clk);
    chk("bp_ready0", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 0;
    req1_valid = 1; req1_a = 16'h0003; req1_b = 16'h0002; req1_sel = 3'b110;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 10) begin
      step();
      @(negedge clk);
      lat++;
    end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'h012CB);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    step();
    rsp_ready = 1;
    step();
    @(negedge clk);
    chk("bp_back_idle", 32'(busy), 32'd0);
    chk("bp_next_grant", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 0;
    drain();

    // Latency with EXEC_CYCLES=4
    step();
    x_req0_valid = 1; x_req0_a = 16'h8000; x_req0_b = 16'h000F; x_req0_sel = 3'b111; x_rsp_ready = 1;
    @(negedge clk);
    chk("lat_ready", 32'(x_req0_ready), 32'd1);
    step();
    x_req0_valid = 0;
    lat = 1;
    @(negedge clk);
    while (!x_rsp_valid && lat < 20) begin
      step();
      @(negedge clk);
      lat++;
    end
    chk("lat_cycles", 32'(lat), 32'd5);
    chk("lat_data", 32'(x_rsp_data), 32'h00001);
    chk("lat_id", 32'(x_rsp_id), 32'd0);
    step();
    @(negedge clk);
    chk("lat_count0", 32'(x_op_count0), 32'd1);
    chk("lat_idle", 32'(x_busy), 32'd0);

    // Reset during EXEC aborts the operation
    step();
    rsp_ready = 1;
    req0_valid = 1; req0_a = 16'h5555; req0_b = 16'h0F0F; req0_sel = 3'b010;
    @(negedge clk);
    chk("abort_ready", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("abort_in_exec", 32'(busy), 32'd1);
    step();
    rst = 0;
    @(negedge clk);
    chk("abort_alu_a", 32'(alu_a), 32'd0);
    chk("abort_alu_b", 32'(alu_b), 32'd0);
    chk("abort_alu_sel", 32'(alu_sel), 32'd0);
    chk("abort_rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_counts", 32'({op_count0, op_count1}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Counter saturation for requester 1
    do_reset();
    run_ops(SAT + 3, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("sat_count1", 32'(op_count1), 32'hF);
    chk("sat_count0", 32'(op_count0), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Two-requester controller that time-shares one approximate_ALU instance (16-bit a/b, 3-bit sel, 17-bit y) between independent clients. It arbitrates round-robin and registers the operands onto the ALU inputs. After a programmable settle time it captures y and returns it with a requester tag over a valid/ready response channel. It sits between client engines and the combinational ALU, so the long LOA/multiplier path is never in a client's timing path.

Parameters:
EXEC_CYCLES, 1, cycles operands are held on the ALU before y is sampled (legal 1..15)
CNT_W, 16, width of per-requester completed-operation counters

Ports:
clk  input  1  clock; all logic rising-edge
rst  input  1  reset, synchronous, active-high
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  16  requester 0 operand a
req0_b  input  16  requester 0 operand b
req0_sel  input  3  requester 0 ALU opcode
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_a  input  16  requester 1 operand a
req1_b  input  16  requester 1 operand b
req1_sel  input  3  requester 1 ALU opcode
alu_a  output  16  registered operand a to the ALU
alu_b  output  16  registered operand b to the ALU
alu_sel  output  3  registered opcode to the ALU
alu_y  input  17  ALU result
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes the response
rsp_data  output  17  captured ALU result
rsp_id  output  1  requester that owns rsp_data
busy  output  1  high in any state other than IDLE
op_count0  output  CNT_W  responses delivered to requester 0, saturating
op_count1  output  CNT_W  responses delivered to requester 1, saturating

Behaviour:
- Clock clk; reset rst is synchronous and active-high.
- On rst: state IDLE. alu_a, alu_b, alu_sel, rsp_data, rsp_id and op_count0/1 are 0. rsp_valid and busy are 0. The round-robin pointer is last=1, so requester 0 wins the first tie.
- Reset mid-operation aborts the operation. Any pending response is discarded and never delivered.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational and asserted only in IDLE, for the granted requester only. At most one ready is high.
  - Grant rule: if only one valid is high, that requester wins. If both are high, the requester other than last wins.
  - On a handshake (valid && ready): register reqN_a/b/sel into alu_a/b/sel, record the grant id, update last, load the exec counter with EXEC_CYCLES-1, and go to EXEC.
  - With no valid: stay in IDLE and hold alu_* at their previous values.
- EXEC:
  - alu_* are held stable.
  - The counter decrements each cycle. In the cycle the counter reads 0, register alu_y into rsp_data and the grant id into rsp_id, set rsp_valid, and go to RESP.
  - Latency from handshake cycle to first rsp_valid cycle is EXEC_CYCLES+1 clocks.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready.
  - When rsp_valid && rsp_ready: clear rsp_valid, increment op_count[rsp_id] (it saturates at all-ones), and go to IDLE.
  - No new request is accepted in the RESP cycle. Minimum spacing between handshakes is EXEC_CYCLES+2 clocks.
- No pipelining: exactly one operation is in flight. The block never reorders operations.
- rsp_data is exactly alu_y. The block performs no width manipulation; bit 16 is the LOA carry for sel 000 and 0 otherwise.
- A requester dropping valid without a handshake is legal and has no effect. Requesters are expected to hold their operands stable while valid is high.
- busy = (state != IDLE).

Test Plan:
- Single op: req0 with a=16'hF0F0, b=16'h0FF0, sel=3'b010, EXEC_CYCLES=1 -> req0_ready in cycle 0, alu_a=F0F0 from cycle 1, rsp_valid in cycle 2 with rsp_data=17'h000F0 and rsp_id=0; with rsp_ready=1, op_count0=1 the next cycle.
- Tie after reset: req0 and req1 valid together, req0 sel=3'b011 with a=16'h00FF, b=16'hFF00; req1 sel=3'b110 with a=16'h0001, b=16'h0004 -> req0 is served first with 17'h0FFFF; req1 is served next with 17'h00010, rsp_id=1; two consecutive ties alternate grants.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id are stable, req ready stays low and busy=1; on rsp_ready=1 the block returns to IDLE.
- Latency parameter: EXEC_CYCLES=4 with sel=3'b111, a=16'h8000, b=16'h000F -> rsp_valid exactly 5 cycles after the handshake, rsp_data=17'h00001.
- Reset mid-EXEC: assert rst during EXEC -> the next cycle all outputs are 0 and state is IDLE; the aborted op produces no response and op_count is unchanged.
- Saturation: force 2^CNT_W+2 completions for req1 (CNT_W reduced to 4 in the bench) -> op_count1 stops at 4'hF.
